// File: rtl/md_iter_engine.sv
// md_iter_engine: radix-2 iterative mult/multu/div/divu datapath.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module md_iter_engine #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_HI,
  output logic [WIDTH-1:0] result_LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, opb;
  logic             is_div, neg_q, neg_r, dz;

  logic             accept, last;
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept = start && !cancel;
  assign last   = (cnt == CW'(WIDTH - 1));

  assign sa    = !op[0] && A[WIDTH-1];
  assign sb    = !op[0] && B[WIDTH-1];
  assign a_mag = sa ? (~A + 1'b1) : A;
  assign b_mag = sb ? (~B + 1'b1) : B;

  // Multiply: hi accumulates, lo holds the shrinking multiplier.
  logic [WIDTH:0]   m_sum;
  logic [WIDTH-1:0] m_hi, m_lo;

  assign m_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign m_hi  = m_sum[WIDTH:1];
  assign m_lo  = {m_sum[0], lo[WIDTH-1:1]};

  // Divide: hi is the partial remainder, lo shifts dividend out, quotient in.
  logic [WIDTH:0]   d_rs, d_diff;
  logic [WIDTH-1:0] d_hi, d_lo;

  assign d_rs   = {hi, lo[WIDTH-1]};
  assign d_diff = d_rs - {1'b0, opb};
  assign d_hi   = d_diff[WIDTH] ? d_rs[WIDTH-1:0] : d_diff[WIDTH-1:0];
  assign d_lo   = {lo[WIDTH-2:0], ~d_diff[WIDTH]};

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign prod     = {hi, lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign q_fix    = dz ? '1 : (neg_q ? (~lo + 1'b1) : lo);
  assign r_fix    = neg_r ? (~hi + 1'b1) : hi;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (cancel)    state_nxt = IDLE;
        else if (last) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            hi     <= '0;
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= (B == '0);
            lo     <= op[1] ? a_mag : b_mag;
            opb    <= op[1] ? b_mag : a_mag;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          hi  <= is_div ? d_hi : m_hi;
          lo  <= is_div ? d_lo : m_lo;
        end
        default: ;
      endcase
    end
  end

  // A divide by zero leaves |A| as remainder; the dividend-sign fix restores A.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      result_HI <= '0;
      result_LO <= '0;
    end else begin
      done <= 1'b0;
      if (state == FIX && !cancel) begin
        done <= 1'b1;
        if (is_div) begin
          result_HI <= r_fix;
          result_LO <= q_fix;
        end else begin
          result_HI <= prod_fix[2*WIDTH-1:WIDTH];
          result_LO <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_md_iter_engine.sv
// tb_md_iter_engine: directed checks of md_iter_engine results,
// latency, busy/done timing, cancel, reset and back-to-back issue.
module tb_md_iter_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        cancel;
  logic        busy, done;
  logic [31:0] result_HI, result_LO;

  int total = 0;
  int bad   = 0;

  md_iter_engine #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .result_HI (result_HI),
    .result_LO (result_LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  // Issue one op and wait (bounded) for done; lat=0 means it never came.
  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output bit bsy_ok);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    bsy_ok = busy;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        if (busy) bsy_ok = 1'b0;
        break;
      end
      if (!busy) bsy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cancel = 1'b0;
    op = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result_HI, result_LO} !== 66'd0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want all 0",
               busy, done, result_HI, result_LO);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_vecs(input string tag, input vec_t v[]);
    int lat;
    bit bo;
    foreach (v[i]) begin
      @(negedge clk);
      launch(v[i].o, v[i].a, v[i].b, lat, bo);
      total++;
      if (lat !== 33 || !bo) begin
        bad++;
        $display("FAIL %s[%0d] timing: lat=%0d busy_ok=%b want 33/1",
                 tag, i, lat, bo);
      end
      total++;
      if (result_HI !== v[i].hi || result_LO !== v[i].lo) begin
        bad++;
        $display("FAIL %s[%0d] result: got %h_%h want %h_%h",
                 tag, i, result_HI, result_LO, v[i].hi, v[i].lo);
      end
    end
  endtask

  task automatic test_mult();
    vec_t v[] = '{
      '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA},
      '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}
    };
    run_vecs("mult", v);
  endtask

  task automatic test_div();
    vec_t v[] = '{
      '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC}
    };
    run_vecs("div", v);
  endtask

  task automatic test_boundary();
    vec_t v[] = '{
      '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF},
      '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF},
      '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}
    };
    run_vecs("bound", v);
  endtask

  task automatic test_interference();
    int lat;
    bit bo;
    bit seen;
    @(negedge clk);
    launch(2'b00, 32'h00001234, 32'h00010000, lat, bo);
    total++;
    if (result_HI !== 32'h0 || result_LO !== 32'h12340000) begin
      bad++;
      $display("FAIL intf_first: got %h_%h want 00000000_12340000",
               result_HI, result_LO);
    end
    // multu 0x10000^2 with a stray div start pulsed mid-flight
    @(negedge clk);
    op = 2'b01; A = 32'h00010000; B = 32'h00010000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 2'b10; A = 32'd5; B = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = 6 + n;
        break;
      end
    end
    total++;
    if (lat !== 33 || result_HI !== 32'h1 || result_LO !== 32'h0) begin
      bad++;
      $display("FAIL intf_ignore: lat=%0d got %h_%h want 33 00000001_00000000",
               lat, result_HI, result_LO);
    end
    // cancel mid-run
    @(negedge clk);
    op = 2'b10; A = 32'd100; B = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL intf_cancel_busy: busy=%b want 0", busy);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total++;
    if (seen || result_HI !== 32'h1 || result_LO !== 32'h0) begin
      bad++;
      $display("FAIL intf_cancel_hold: done_seen=%b got %h_%h want 0 00000001_00000000",
               seen, result_HI, result_LO);
    end
    // cancel together with start in IDLE
    @(negedge clk);
    op = 2'b00; A = 32'd3; B = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL intf_idle_cancel: busy=%b want 0", busy);
    end
    // reset mid-run
    @(negedge clk);
    op = 2'b00; A = 32'd9; B = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, result_HI, result_LO} !== 66'd0) begin
      bad++;
      $display("FAIL intf_reset: busy=%b done=%b hi=%h lo=%h want all 0",
               busy, done, result_HI, result_LO);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    bit bo1, bo2;
    logic [31:0] h1, l1;
    @(negedge clk);
    launch(2'b00, 32'd7, 32'd6, lat1, bo1);
    h1 = result_HI; l1 = result_LO;
    // still inside the done cycle: issue the next op immediately
    launch(2'b11, 32'd100, 32'd7, lat2, bo2);
    total++;
    if (lat1 !== 33 || h1 !== 32'h0 || l1 !== 32'h2A) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d got %h_%h want 33 00000000_0000002a",
               lat1, h1, l1);
    end
    total++;
    if (lat2 !== 33 || !bo2 || result_HI !== 32'h2 || result_LO !== 32'hE) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d busy_ok=%b got %h_%h want 33 1 00000002_0000000e",
               lat2, bo2, result_HI, result_LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_boundary();
    test_interference();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
